// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: oversampling UART receiver with majority-vote sampling, parity/stop checking and a one-word hold register
module uart_rx_gen2 #(
  parameter int FREQ       = 50_000_000,
  parameter int BAUDRATE   = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int DIV_RAW = FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_MAX = CW'(DIV - 1);
  localparam logic [PW-1:0] P_LO = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] P_MID = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] P_HI = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] P_MAX = PW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_MAX = BW'(DATA_BITS - 1);
  localparam logic S_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD = PARITY == 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic                 tick;
  logic [PW-1:0]        phase;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           smp;
  logic                 armed;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 maj;
  logic                 done;

  assign rx_s = sync[1];
  assign tick = cnt == C_MAX;
  assign maj = (smp[0] & smp[1]) | (rx_s & (smp[0] | smp[1]));
  assign done = tick && state == S_STOP && phase == P_HI && stop_cnt == S_LAST;
  assign busy = state != S_IDLE;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx};

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      smp        <= '0;
      armed      <= 1'b0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;
      // a completed frame only replaces the held word if the slot is free or being drained this clk
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= shreg;
        parity_err <= perr;
        frame_err  <= ferr | ~maj;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state == S_IDLE && rx_s) armed <= 1'b1;
      if (tick) begin
        if (phase == P_LO || phase == P_MID) smp <= {smp[0], rx_s};
        phase <= (state == S_IDLE || phase == P_MAX) ? '0 : phase + 1'b1;
        case (state)
          S_IDLE:
            if (armed && !rx_s) begin
              state <= S_START;
              perr  <= 1'b0;
              ferr  <= 1'b0;
            end
          S_START:
            if (phase == P_HI && maj) state <= S_IDLE;
            else if (phase == P_MAX) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          S_DATA: begin
            if (phase == P_HI) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (phase == P_MAX) begin
              bit_cnt  <= bit_cnt + 1'b1;
              stop_cnt <= 1'b0;
              if (bit_cnt == B_MAX) state <= PARITY != 0 ? S_PAR : S_STOP;
            end
          end
          S_PAR: begin
            if (phase == P_HI) perr <= maj ^ (^shreg) ^ ODD;
            if (phase == P_MAX) state <= S_STOP;
          end
          S_STOP:
            if (phase == P_HI) begin
              ferr <= ferr | ~maj;
              if (done) begin
                state <= S_IDLE;
                armed <= 1'b0;
              end
            end else if (phase == P_MAX) stop_cnt <= stop_cnt + 1'b1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2: directed + random frames into an 8N1 and an 8E1 receiver, checked against expected words
module tb_uart_rx_gen2;
  logic clk = 0, rst = 1, rx_ready = 1;
  logic rx_a = 1, rx_b = 1;
  logic [7:0] rx_data_a, rx_data_b;
  logic rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a;
  logic rx_valid_b, parity_err_b, frame_err_b, overrun_b, busy_b;
  int total = 0, bad = 0;
  int vcnt_a = 0, ov_a = 0;
  bit busy_seen_a = 0;
  logic [9:0] qa[$], qb[$];

  always #5 clk = ~clk;

  uart_rx_gen2 #(.FREQ(1_843_200), .BAUDRATE(115200), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a), .busy(busy_a));

  uart_rx_gen2 #(.FREQ(1_843_200), .BAUDRATE(115200), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b), .busy(busy_b));

  // every handshake is one delivered word: {frame_err, parity_err, data}
  always @(negedge clk) begin
    if (rx_valid_a && rx_ready) qa.push_back({frame_err_a, parity_err_a, rx_data_a});
    if (rx_valid_b && rx_ready) qb.push_back({frame_err_b, parity_err_b, rx_data_b});
    vcnt_a += int'(rx_valid_a);
    ov_a += int'(overrun_a);
    if (busy_a) busy_seen_a = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input bit sel, input bit v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit par, input bit pb, input bit sb);
    line(sel, 0);
    step(16);
    for (int i = 0; i < 8; i++) begin
      line(sel, d[i]);
      step(16);
    end
    if (par) begin
      line(sel, pb);
      step(16);
    end
    line(sel, sb);
    step(20);
  endtask

  task automatic get_word(input bit sel, output logic [9:0] w);
    int n = 0;
    while ((sel ? qb.size() : qa.size()) == 0 && n < 300) begin
      step(1);
      n++;
    end
    chk("word_avail", 32'((sel ? qb.size() : qa.size()) != 0), 1);
    w = '0;
    if (sel && qb.size() != 0) w = qb.pop_front();
    else if (!sel && qa.size() != 0) w = qa.pop_front();
  endtask

  initial begin
    logic [9:0] w;
    logic [7:0] d;
    bit pb;
    int v0, o0;
    step(3);
    chk("rst_outs_a", {rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a, rx_data_a}, 0);
    chk("rst_outs_b", {rx_valid_b, parity_err_b, frame_err_b, overrun_b, busy_b, rx_data_b}, 0);
    rst = 0;
    step(10);

    v0 = vcnt_a;
    send(0, 8'hA5, 0, 0, 1);
    get_word(0, w);
    chk("8n1_a5", w, {2'b00, 8'hA5});
    chk("8n1_valid_1clk", vcnt_a - v0, 1);
    chk("8n1_no_overrun", ov_a, 0);
    repeat (5) begin
      d = 8'($urandom);
      send(0, d, 0, 0, 1);
      get_word(0, w);
      chk("8n1_rand", w, {2'b00, d});
    end

    send(1, 8'h03, 1, 1, 1);
    get_word(1, w);
    chk("8e1_03_badpar", w, {2'b01, 8'h03});
    send(1, 8'h03, 1, 0, 1);
    get_word(1, w);
    chk("8e1_03_goodpar", w, {2'b00, 8'h03});
    repeat (6) begin
      d = 8'($urandom);
      pb = 1'($urandom);
      send(1, d, 1, pb, 1);
      get_word(1, w);
      chk("8e1_rand", w, {1'b0, pb ^ (^d), d});
    end

    send(0, 8'h55, 0, 0, 0);
    get_word(0, w);
    chk("break_55_ferr", w, {2'b10, 8'h55});
    step(80);
    chk("break_no_rearm", qa.size(), 0);
    chk("break_idle", busy_a, 0);
    line(0, 1);
    step(20);
    send(0, 8'h5A, 0, 0, 1);
    get_word(0, w);
    chk("after_break_5a", w, {2'b00, 8'h5A});

    busy_seen_a = 0;
    line(0, 0);
    step(4);
    line(0, 1);
    step(40);
    chk("glitch_busy_seen", busy_seen_a, 1);
    chk("glitch_idle", busy_a, 0);
    chk("glitch_no_word", qa.size(), 0);
    chk("glitch_no_valid", rx_valid_a, 0);

    rx_ready = 0;
    o0 = ov_a;
    send(0, 8'h11, 0, 0, 1);
    chk("ovr_first_overrun", ov_a - o0, 0);
    send(0, 8'h22, 0, 0, 1);
    chk("ovr_pulse_1clk", ov_a - o0, 1);
    chk("ovr_held_valid", rx_valid_a, 1);
    chk("ovr_held_data", rx_data_a, 8'h11);
    rx_ready = 1;
    get_word(0, w);
    chk("ovr_drained", w, {2'b00, 8'h11});
    step(2);
    chk("ovr_cleared", rx_valid_a, 0);
    chk("ovr_no_extra", qa.size(), 0);

    line(0, 0);
    step(16);
    for (int i = 0; i < 4; i++) begin
      line(0, i[0]);
      step(16);
    end
    line(0, 1);
    step(8);
    chk("mid_busy", busy_a, 1);
    rst = 1;
    #1;
    chk("rst_mid_outs", {rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a, rx_data_a}, 0);
    step(3);
    rst = 0;
    step(20);
    chk("rst_no_output", qa.size(), 0);
    send(0, 8'h3C, 0, 0, 1);
    get_word(0, w);
    chk("rst_then_3c", w, {2'b00, 8'h3C});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
